// File: rtl/sr_mul_pkg.sv
// rtl/sr_mul_pkg.sv - shared constants and helpers for the iterative multiplier and its control unit
package sr_mul_pkg;

  localparam int XLEN = 32;

  // Partial product of x with the k-th w-bit digit of y, placed at its weight, low XLEN bits kept
  function automatic logic [XLEN-1:0] mul_chunk(input logic [XLEN-1:0] x,
                                                input logic [XLEN-1:0] y,
                                                input int              k,
                                                input int              w);
    logic [63:0]     mask;
    logic [XLEN-1:0] digit;
    mask  = (64'd1 << w) - 64'd1;
    digit = XLEN'((64'(y) >> (k * w)) & mask);
    return (x * digit) << (k * w);
  endfunction

  function automatic bit mul_n_legal(input int n);
    return (n == 2) || (n == 4) || (n == 8) || (n == 16) || (n == 32);
  endfunction

endpackage

// File: rtl/sr_mul_chunk.sv
// rtl/sr_mul_chunk.sv - combinational 32 x W partial product, shifted to the weight of the selected digit
module sr_mul_chunk
  import sr_mul_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [XLEN-1:0]      x_i,
  input  logic [XLEN-1:0]      y_i,
  input  logic [$clog2(N)-1:0] step_i,
  output logic [XLEN-1:0]      pp_o
);

  localparam int W = XLEN / N;

  logic [31:0]     shamt;
  logic [W-1:0]    digit;
  logic [XLEN-1:0] prod;

  always_comb begin
    shamt = 32'(step_i) * W;
    digit = W'(y_i >> shamt);
    prod  = x_i * XLEN'(digit);
    pp_o  = prod << shamt;
  end

endmodule

// File: rtl/sr_mul_iter.sv
// rtl/sr_mul_iter.sv - N-cycle RV32M MUL unit answering the control unit's multiply stall
// SR_MUL_ITER_STATS_EN adds the mulCount completed-multiply counter output.
module sr_mul_iter
  import sr_mul_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
`ifdef SR_MUL_ITER_STATS_EN
  ,
  output logic [31:0]     mulCount
`endif
);

  localparam int CW = $clog2(N);

  if (!mul_n_legal(N)) begin : g_bad_n
    $error("sr_mul_iter: N=%0d is not one of 2, 4, 8, 16, 32", N);
  end

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic            idle;
  logic [XLEN-1:0] x_sel, y_sel, pp, sum;

  assign idle = (cnt_q == '0);
  assign busy = !idle;
  assign done = (cnt_q == CW'(N - 1));

  // Step 0 reads the live register-file operands; later steps use the copies latched at step 0
  assign x_sel = idle ? srcA : opa_q;
  assign y_sel = idle ? srcB : opb_q;

  sr_mul_chunk #(.N(N)) u_chunk (
    .x_i    (x_sel),
    .y_i    (y_sel),
    .step_i (cnt_q),
    .pp_o   (pp)
  );

  assign sum    = idle ? pp : acc_q + pp;
  assign result = (idle && !start) ? '0 : sum;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    if (idle) begin
      if (start) begin
        cnt_d = CW'(1);
        acc_d = pp;
        opa_d = srcA;
        opb_d = srcB;
      end
    end else if (done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

`ifdef SR_MUL_ITER_STATS_EN
  logic [31:0] mul_count_q, mul_count_d;

  assign mul_count_d = done ? mul_count_q + 32'd1 : mul_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_count_q <= '0;
    end else begin
      mul_count_q <= mul_count_d;
    end
  end

  assign mulCount = mul_count_q;
`endif

endmodule

// File: tb/tb_sr_mul_iter.sv
// tb/tb_sr_mul_iter.sv - scoreboard bench for sr_mul_iter against a plain a*b model with cycle timing
module tb_sr_mul_iter #(
  parameter int N = 4
);

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [31:0] srcA  = '0;
  logic [31:0] srcB  = '0;
  logic [31:0] result;
  logic        busy;
  logic        done;
`ifdef SR_MUL_ITER_STATS_EN
  logic [31:0] mulCount;
`endif

  always #5 clk = ~clk;

  sr_mul_iter #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .srcA   (srcA),
    .srcB   (srcB),
    .result (result),
    .busy   (busy),
    .done   (done)
`ifdef SR_MUL_ITER_STATS_EN
    ,
    .mulCount (mulCount)
`endif
  );

  typedef struct {
    logic [31:0] prod;
    int          t0;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   completed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
    end
  endtask

  // A MUL accepted in cycle t is busy over t+1..t+N-1 and completes in cycle t+N-1
  always @(negedge clk) begin
    logic exp_busy;
    logic exp_done;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    if (sb_q.size() != 0) begin
      exp_busy = (cyc > sb_q[0].t0);
      exp_done = (cyc == sb_q[0].due);
    end
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
`ifdef SR_MUL_ITER_STATS_EN
    check("mulCount", mulCount, 32'(completed));
`endif
    if (exp_done) begin
      check("result", result, sb_q[0].prod);
      void'(sb_q.pop_front());
      completed++;
    end else if (sb_q.size() == 0 && !start) begin
      check("idle_result", result, 32'd0);
    end
  end

  task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b);
    start = s;
    srcA  = a;
    srcB  = b;
    if (s && sb_q.size() == 0) sb_q.push_back('{a * b, cyc, cyc + N - 1});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    sb_q.delete();
    completed = 0;
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);

    drive(1'b1, 32'd3, 32'd5);
    idle_cycles(N + 1);
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle_cycles(N);
    drive(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    idle_cycles(N);

    drive(1'b1, 32'd7, 32'd6);
    repeat (N) drive(1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 2 * N + 1; i++) drive(1'b1, $urandom, $urandom);
    idle_cycles(N);

    drive(1'b1, 32'd3, 32'd3);
    drive(1'b0, $urandom, $urandom);
    do_reset();
    drive(1'b0, $urandom, $urandom);
    drive(1'b1, 32'd9, 32'd9);
    idle_cycles(N);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      else drive($urandom_range(0, 2) == 0, $urandom, $urandom);
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 4 * N + 8) begin
      drive(1'b0, 32'd0, 32'd0);
      guard++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
